// File: rtl/keypad_scanner.sv
// 4x4 push-button matrix scanner: row-by-row sampling, per-key debounce,
// and a valid/ready press-event queue of depth one with overrun signalling.
module keypad_scanner #(
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col_n,
   output logic [3:0]  row_n,
   output logic [15:0] keys_down,
   output logic        key_valid,
   output logic [3:0]  key_code,
   input  logic        key_ready,
   output logic        key_overrun
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] DB_LAST     = 4'(DEBOUNCE_SCANS - 1);

   logic [1:0]  rowCnt;
   logic [7:0]  settleCnt;
   logic [3:0]  syncMeta;
   logic [3:0]  syncStage;
   logic [3:0]  syncCol;
   logic        sampleEn;

   logic [15:0] downNext;
   logic [15:0] risen;
   logic [3:0]  dbCnt     [16];
   logic [3:0]  dbCntNext [16];
   logic [3:0]  keyIdx;
   logic        rawBit;

   logic        pendValid;
   logic        pendMulti;
   logic [3:0]  pendCode;
   logic [3:0]  pendCodeNext;
   logic        pendMultiNext;

   logic        validNext;
   logic [3:0]  codeNext;
   logic        overrunNext;

   assign syncCol  = ~syncStage;
   assign sampleEn = (settleCnt == SETTLE_LAST);
   assign row_n    = ~(4'b1000 >> rowCnt);

   // Column synchronizer and the row/settle sequencer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         syncMeta  <= 4'b1111;
         syncStage <= 4'b1111;
         rowCnt    <= 2'd0;
         settleCnt <= 8'd0;
      end else begin
         syncMeta  <= col_n;
         syncStage <= syncMeta;
         if (sampleEn) begin
            settleCnt <= 8'd0;
            rowCnt    <= rowCnt + 2'd1;
         end else begin
            settleCnt <= settleCnt + 8'd1;
         end
      end
   end

   // Debounce only the four keys of the row being sampled this cycle
   always_comb begin
      downNext  = keys_down;
      risen     = '0;
      dbCntNext = dbCnt;
      keyIdx    = '0;
      rawBit    = 1'b0;
      if (sampleEn) begin
         for (int c = 0; c < 4; c++) begin
            keyIdx = {rowCnt, 2'(c)};
            rawBit = syncCol[2'(3 - c)];
            if (rawBit == keys_down[keyIdx]) begin
               dbCntNext[keyIdx] = '0;
            end else if (dbCnt[keyIdx] == DB_LAST) begin
               downNext[keyIdx]  = rawBit;
               dbCntNext[keyIdx] = '0;
               risen[keyIdx]     = rawBit;
            end else begin
               dbCntNext[keyIdx] = dbCnt[keyIdx] + 4'd1;
            end
         end
      end
   end

   // Lowest newly pressed index wins; any other new press is reported as dropped
   always_comb begin
      pendCodeNext = '0;
      for (int k = 15; k >= 0; k--) begin
         if (risen[k]) pendCodeNext = 4'(k);
      end
      pendMultiNext = |(risen & (risen - 16'd1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         keys_down <= '0;
         for (int k = 0; k < 16; k++) dbCnt[k] <= '0;
         pendValid <= 1'b0;
         pendCode  <= '0;
         pendMulti <= 1'b0;
      end else begin
         keys_down <= downNext;
         for (int k = 0; k < 16; k++) dbCnt[k] <= dbCntNext[k];
         pendValid <= |risen;
         pendCode  <= pendCodeNext;
         pendMulti <= pendMultiNext;
      end
   end

   // Single-entry event register; an accept and a new load can share a cycle
   always_comb begin
      validNext   = key_valid;
      codeNext    = key_code;
      overrunNext = 1'b0;
      if (pendValid) begin
         if (key_valid && !key_ready) begin
            overrunNext = 1'b1;
         end else begin
            validNext   = 1'b1;
            codeNext    = pendCode;
            overrunNext = pendMulti;
         end
      end else if (key_valid && key_ready) begin
         validNext = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_overrun <= 1'b0;
      end else begin
         key_valid   <= validNext;
         key_code    <= codeNext;
         key_overrun <= overrunNext;
      end
   end

endmodule
